// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding and default sizing.
// Contents: rx_state_t (IDLE, START, DATA, STOP), OVERSAMPLE_DEF, DATA_BITS_DEF,
// TICK_W (tick-counter width for the default oversample rate).
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;
    localparam int TICK_W         = $clog2(OVERSAMPLE_DEF);
endpackage

// File: rtl/u_rx_if.sv
// u_rx_if: serial-side and host-side signals of the UART receiver.
// Signals: data_in (serial line), baud_en_rx (oversample tick),
// rx_active, data_out[DATA_BITS], rx_data_ready (host side).
// Modports: master drives line/tick and observes outputs; slave is the receiver.
interface u_rx_if #(parameter int DATA_BITS = 8);
    logic                 data_in;
    logic                 baud_en_rx;
    logic                 rx_active;
    logic [DATA_BITS-1:0] data_out;
    logic                 rx_data_ready;
    modport master (output data_in, baud_en_rx, input rx_active, data_out, rx_data_ready);
    modport slave  (input data_in, baud_en_rx, output rx_active, data_out, rx_data_ready);
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for the RX line, optional 3-sample majority.
// Ports: clk, rst_n (async active-low), d (raw line), tick (oversample enable),
// rx_s (synchronized line), rx_v (bit value used for sampling decisions).
// RX_MAJORITY_EN: rx_v is the 2-of-3 vote of rx_s over the current and two previous ticks.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    input  logic tick,
    output logic rx_s,
    output logic rx_v
);
    logic [1:0] ff;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ff <= 2'b11;
        else ff <= {ff[0], d};
    assign rx_s = ff[1];
`ifdef RX_MAJORITY_EN
    logic [1:0] hist;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) hist <= 2'b11;
        else if (tick) hist <= {hist[0], rx_s};
    assign rx_v = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    logic unused_tick;
    assign unused_tick = tick;
    assign rx_v = rx_s;
`endif
endmodule

// File: rtl/u_rx.sv
// u_rx: 8N1 UART receiver with oversampling driven by an external baud tick.
// Ports: clk, rst_n (async active-low), bus (u_rx_if.slave: data_in, baud_en_rx,
// rx_active, data_out, rx_data_ready).
// RX_MAJORITY_EN: start validation completes at tick OVERSAMPLE/2+1 and every
// sample is a 3-tick majority; bit boundaries stay the same.
module u_rx import uart_pkg::*; #(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    u_rx_if.slave bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS);
`ifdef RX_MAJORITY_EN
    localparam int START_END = OVERSAMPLE / 2 + 1;
`else
    localparam int START_END = OVERSAMPLE / 2 - 1;
`endif
    rx_state_t            state, state_n;
    logic [TW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        idx, idx_n;
    logic [DATA_BITS-1:0] sh, sh_n, dout;
    logic                 armed, armed_n, load, rdy, act, rx_s, rx_v;
    uart_rx_sync u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (bus.data_in),
        .tick (bus.baud_en_rx),
        .rx_s (rx_s),
        .rx_v (rx_v)
    );
    // armed blocks restarting after a framing error until the line is seen high
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sh_n    = sh;
        armed_n = armed;
        load    = 1'b0;
        if (bus.baud_en_rx)
            case (state)
                IDLE: begin
                    armed_n = armed | rx_s;
                    if (armed && !rx_s) begin
                        state_n = START;
                        cnt_n   = '0;
                    end
                end
                START: begin
                    cnt_n = (cnt == TW'(START_END)) ? '0 : cnt + 1'b1;
                    idx_n = '0;
                    if (cnt == TW'(START_END)) state_n = rx_v ? IDLE : DATA;
                end
                DATA: begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == TW'(OVERSAMPLE - 1)) begin
                        sh_n    = {rx_v, sh[DATA_BITS-1:1]};
                        idx_n   = idx + 1'b1;
                        state_n = (idx == IW'(DATA_BITS - 1)) ? STOP : DATA;
                    end
                end
                STOP: begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == TW'(OVERSAMPLE - 1)) begin
                        state_n = IDLE;
                        load    = rx_v;
                        armed_n = rx_v;
                    end
                end
            endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
            armed <= 1'b1;
            dout  <= '0;
            rdy   <= 1'b0;
            act   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            sh    <= sh_n;
            armed <= armed_n;
            rdy   <= load;
            act   <= (state_n != IDLE);
            if (load) dout <= sh;
        end
    assign bus.data_out      = dout;
    assign bus.rx_data_ready = rdy;
    assign bus.rx_active     = act;
endmodule

// File: tb/tb_u_rx.sv
// tb_u_rx: scoreboard bench for u_rx; expected bytes are queued per frame, a monitor checks each ready pulse.
`timescale 1ns/1ps
module tb_u_rx;
    logic clk = 1'b0;
    logic rst_n;
    int checks = 0;
    int errors = 0;
    int div = 4;
    int ready_cnt = 0;
    logic [7:0] exp_q[$];
    u_rx_if #(.DATA_BITS(8)) bus ();
    u_rx dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask
    initial begin
        int tcnt = 0;
        bus.baud_en_rx = 1'b0;
        forever begin
            @(negedge clk);
            tcnt = (tcnt + 1 >= div) ? 0 : tcnt + 1;
            bus.baud_en_rx = (tcnt == 0);
        end
    end
    task automatic wait_ticks(input int k);
        for (int n = 0; n < k;) begin
            @(posedge clk);
            if (bus.baud_en_rx) n++;
        end
        #1;
    endtask
    task automatic send_bit(input logic b);
        bus.data_in = b;
        wait_ticks(16);
    endtask
    task automatic send_frame(input logic [7:0] v, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
        send_bit(stop);
    endtask
    initial begin
        logic prev_rdy = 1'b0;
        logic prev_act = 1'b0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_rdy = 1'b0;
                prev_act = 1'b0;
            end else begin
                if (prev_rdy) chk("ready_width", bus.rx_data_ready, 0);
                if (bus.rx_data_ready) begin
                    ready_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ready: got 0x%0h expected no pulse", bus.data_out);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data_out", bus.data_out, e);
                    end
                    chk("active_before_ready", prev_act, 1);
                    chk("active_fall_at_ready", bus.rx_active, 0);
                end
                prev_rdy = bus.rx_data_ready;
                prev_act = bus.rx_active;
            end
        end
    end
    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks + 1, errors + 1);
        $fatal(1, "watchdog");
    end
    initial begin
        int rc;
        logic [7:0] v99;
        rst_n = 1'b0;
        bus.data_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data_out", bus.data_out, 0);
        chk("reset_ready", bus.rx_data_ready, 0);
        chk("reset_active", bus.rx_active, 0);
        @(negedge clk) rst_n = 1'b1;
        wait_ticks(20);
        exp_q.push_back(8'hAA);
        send_frame(8'hAA, 1'b1);
        send_bit(1'b1);
        div = 1;
        wait_ticks(4);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        send_bit(1'b1);
        div = 4;
        wait_ticks(4);
        rc = ready_cnt;
        bus.data_in = 1'b0;
        wait_ticks(4);
        bus.data_in = 1'b1;
        wait_ticks(32);
        chk("false_start_active", bus.rx_active, 0);
        chk("false_start_ready_cnt", ready_cnt, rc);
        chk("false_start_data", bus.data_out, 8'h3C);
        send_frame(8'h55, 1'b0);
        wait_ticks(16);
        chk("break_no_retrigger", bus.rx_active, 0);
        chk("framing_ready_cnt", ready_cnt, rc);
        chk("framing_data_held", bus.data_out, 8'h3C);
        send_bit(1'b1);
        send_bit(1'b1);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1);
        send_bit(1'b1);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hFE);
        send_frame(8'h01, 1'b1);
        send_frame(8'hFE, 1'b1);
        send_bit(1'b1);
        v99 = 8'h99;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(v99[i]);
        bus.data_in = v99[4];
        wait_ticks(5);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("midframe_reset_data", bus.data_out, 0);
        chk("midframe_reset_active", bus.rx_active, 0);
        chk("midframe_reset_ready", bus.rx_data_ready, 0);
        @(negedge clk) rst_n = 1'b1;
        bus.data_in = 1'b1;
        wait_ticks(32);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        send_bit(1'b1);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("total_ready_pulses", ready_cnt, 6);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
